// File: rtl/ir_beat_detector_pkg.sv
// Shared definitions for the IR beat detector and its neighbours in the IR chain.
package ir_beat_detector_pkg;

  // Sample width produced by the IR FIR filter.
  localparam int DATA_W_DEF = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2
  } state_t;

endpackage

// File: rtl/ir_beat_detector_if.sv
// Sample stream in, beat report out, for the IR beat detector.
interface ir_beat_detector_if
  import ir_beat_detector_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 12
);

  logic              In_Valid;
  logic [DATA_W-1:0] In_IR_Filtered;
  logic              Beat_Valid;
  logic [DATA_W-1:0] Peak_Value;
  logic [DATA_W-1:0] Trough_Value;
  logic [CNT_W-1:0]  Beat_Interval;
  logic              No_Signal;

  modport master (
    output In_Valid, In_IR_Filtered,
    input  Beat_Valid, Peak_Value, Trough_Value, Beat_Interval, No_Signal
  );

  modport slave (
    input  In_Valid, In_IR_Filtered,
    output Beat_Valid, Peak_Value, Trough_Value, Beat_Interval, No_Signal
  );

endinterface

// File: rtl/ir_beat_detector_interval_counter.sv
// Counts valid samples since the last confirmed peak; flags the last count
// before the loss-of-signal window expires.
module beat_interval_counter #(
  parameter int CNT_W        = 12,
  parameter int MAX_INTERVAL = 3000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  // Clear wins over enable so a peak sample restarts the interval at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + CNT_W'(1);
  end

  assign tc = (cnt == CNT_W'(MAX_INTERVAL - 1));

endmodule

// File: rtl/ir_beat_detector.sv
// Hysteresis peak/trough tracker on the filtered IR stream; reports each beat's
// peak, preceding trough and interval, and flags loss of signal.
module ir_beat_detector
  import ir_beat_detector_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int CNT_W        = 12,
  parameter int HYST         = 256,
  parameter int MIN_INTERVAL = 40,
  parameter int MAX_INTERVAL = 3000
) (
  input  logic CLK_Filter,
  input  logic rst_n,
  ir_beat_detector_if.slave bus
);

  state_t            state, state_next;
  logic [DATA_W-1:0] run_max, run_min, trough_reg;
  logic [DATA_W-1:0] max_next, min_next, trough_next;
  logic              have_prev, prev_next;
  logic [DATA_W-1:0] x, max_upd, min_upd;
  logic [CNT_W-1:0]  cnt;
  logic              tc, cnt_en, cnt_clr;
  logic              peak_ok, trough_ok, beat, timeout;

  // Strictly greater than HYST, measured one bit wider so the difference never wraps.
  function automatic logic exceeds_hyst(input logic [DATA_W-1:0] hi,
                                        input logic [DATA_W-1:0] lo);
    logic [DATA_W:0] diff;
    diff = {1'b0, hi} - {1'b0, lo};
    return (hi >= lo) && (diff > (DATA_W+1)'(HYST));
  endfunction

  assign x         = bus.In_IR_Filtered;
  assign max_upd   = (x > run_max) ? x : run_max;
  assign min_upd   = (x < run_min) ? x : run_min;
  assign peak_ok   = exceeds_hyst(max_upd, x) && (cnt >= CNT_W'(MIN_INTERVAL));
  assign trough_ok = exceeds_hyst(x, min_upd);

  beat_interval_counter #(
    .CNT_W        (CNT_W),
    .MAX_INTERVAL (MAX_INTERVAL)
  ) u_counter (
    .clk   (CLK_Filter),
    .rst_n (rst_n),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .cnt   (cnt),
    .tc    (tc)
  );

  // Next-state logic; a peak beats a timeout on the same sample, and a
  // timeout sample is dropped without touching the trackers.
  always_comb begin
    state_next  = state;
    max_next    = run_max;
    min_next    = run_min;
    trough_next = trough_reg;
    prev_next   = have_prev;
    beat        = 1'b0;
    timeout     = 1'b0;
    cnt_en      = 1'b0;
    cnt_clr     = 1'b0;
    if (bus.In_Valid) begin
      case (state)
        IDLE: begin
          max_next   = x;
          min_next   = x;
          prev_next  = 1'b0;
          cnt_clr    = 1'b1;
          state_next = RISE;
        end
        RISE: begin
          if (peak_ok) begin
            beat       = have_prev;
            prev_next  = 1'b1;
            min_next   = x;
            cnt_clr    = 1'b1;
            state_next = FALL;
          end else if (tc) begin
            timeout    = 1'b1;
            state_next = IDLE;
          end else begin
            max_next = max_upd;
            cnt_en   = 1'b1;
          end
        end
        FALL: begin
          if (tc) begin
            timeout    = 1'b1;
            state_next = IDLE;
          end else begin
            min_next = min_upd;
            cnt_en   = 1'b1;
            if (trough_ok) begin
              trough_next = min_upd;
              max_next    = x;
              state_next  = RISE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Tracker and state registers.
  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      run_max    <= '0;
      run_min    <= '0;
      trough_reg <= '0;
      have_prev  <= 1'b0;
    end else begin
      state      <= state_next;
      run_max    <= max_next;
      run_min    <= min_next;
      trough_reg <= trough_next;
      have_prev  <= prev_next;
    end
  end

  // Registered beat report; results hold between strobes.
  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      bus.Beat_Valid    <= 1'b0;
      bus.Peak_Value    <= '0;
      bus.Trough_Value  <= '0;
      bus.Beat_Interval <= '0;
      bus.No_Signal     <= 1'b0;
    end else begin
      bus.Beat_Valid <= beat;
      if (beat) begin
        bus.Peak_Value    <= run_max;
        bus.Trough_Value  <= trough_reg;
        bus.Beat_Interval <= cnt + CNT_W'(1);
        bus.No_Signal     <= 1'b0;
      end else if (timeout) begin
        bus.No_Signal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ir_beat_detector.sv
// Bench for ir_beat_detector: directed waveforms plus random triangles, all
// checked cycle by cycle against a sample-level reference model.
module tb_ir_beat_detector;

  localparam int DATA_W       = 20;
  localparam int CNT_W        = 12;
  localparam int HYST         = 256;
  localparam int MIN_INTERVAL = 40;
  localparam int MAX_INTERVAL = 3000;
  localparam int XMAX         = (1 << DATA_W) - 1;

  logic clk;
  logic rst_n;

  ir_beat_detector_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  ir_beat_detector #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .HYST(HYST),
    .MIN_INTERVAL(MIN_INTERVAL), .MAX_INTERVAL(MAX_INTERVAL)
  ) dut (
    .CLK_Filter (clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: tracking flag, direction flag, running extremes.
  bit m_active, m_rising, m_prev;
  int m_hi, m_lo, m_tr, m_cnt;
  logic              e_bv, e_ns;
  logic [DATA_W-1:0] e_peak, e_trough;
  logic [CNT_W-1:0]  e_int;

  int bq_idx[$];
  int bq_peak[$];
  int bq_trough[$];
  int bq_int[$];

  task automatic model_reset();
    m_active = 0; m_rising = 0; m_prev = 0;
    m_hi = 0; m_lo = 0; m_tr = 0; m_cnt = 0;
    e_bv = 0; e_ns = 0; e_peak = '0; e_trough = '0; e_int = '0;
  endtask

  task automatic model_step(input bit v, input int x);
    e_bv = 1'b0;
    if (!v) return;
    if (!m_active) begin
      m_hi = x; m_lo = x; m_cnt = 0; m_prev = 0;
      m_active = 1; m_rising = 1;
      return;
    end
    if (m_rising) begin
      if (x > m_hi) m_hi = x;
      if ((m_hi - x > HYST) && (m_cnt >= MIN_INTERVAL)) begin
        if (m_prev) begin
          e_bv     = 1'b1;
          e_peak   = DATA_W'(m_hi);
          e_trough = DATA_W'(m_tr);
          e_int    = CNT_W'(m_cnt + 1);
          e_ns     = 1'b0;
        end
        m_prev = 1; m_cnt = 0; m_rising = 0; m_lo = x;
        return;
      end
    end else if (m_cnt + 1 < MAX_INTERVAL) begin
      if (x < m_lo) m_lo = x;
      if (x - m_lo > HYST) begin
        m_tr = m_lo; m_hi = x; m_rising = 1;
      end
    end
    m_cnt++;
    if (m_cnt == MAX_INTERVAL) begin
      e_ns = 1'b1;
      m_active = 0;
    end
  endtask

  // Drive one clock's input (called at a falling edge), then compare at the next falling edge.
  task automatic cycle(input bit v, input int x);
    bus.In_Valid       = v;
    bus.In_IR_Filtered = DATA_W'(x);
    model_step(v, x);
    @(negedge clk);
    checks++;
    if (bus.Beat_Valid !== e_bv || bus.Peak_Value !== e_peak || bus.Trough_Value !== e_trough ||
        bus.Beat_Interval !== e_int || bus.No_Signal !== e_ns) begin
      failures++;
      if (failures <= 30)
        $display("FAIL model cyc=%0d got bv=%b pk=%0d tr=%0d int=%0d ns=%b exp bv=%b pk=%0d tr=%0d int=%0d ns=%b",
                 cyc, bus.Beat_Valid, bus.Peak_Value, bus.Trough_Value, bus.Beat_Interval, bus.No_Signal,
                 e_bv, e_peak, e_trough, e_int, e_ns);
    end
    if (bus.Beat_Valid === 1'b1) begin
      bq_idx.push_back(cyc);
      bq_peak.push_back(int'(bus.Peak_Value));
      bq_trough.push_back(int'(bus.Trough_Value));
      bq_int.push_back(int'(bus.Beat_Interval));
    end
    cyc++;
  endtask

  task automatic clear_beats();
    bq_idx.delete(); bq_peak.delete(); bq_trough.delete(); bq_int.delete();
  endtask

  function automatic int tri_val(input int k, input int lo, input int hi, input int period);
    int ph, half;
    half = period / 2;
    ph   = k % period;
    if (ph <= half) return lo + (hi - lo) * ph / half;
    return hi - (hi - lo) * (ph - half) / half;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.In_Valid = 1'b0;
    bus.In_IR_Filtered = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (bus.Beat_Valid !== 1'b0 || bus.Peak_Value !== '0 || bus.Trough_Value !== '0 ||
        bus.Beat_Interval !== '0 || bus.No_Signal !== 1'b0) begin
      failures++;
      $display("FAIL %s got bv=%b pk=%0d tr=%0d int=%0d ns=%b exp all zero", name,
               bus.Beat_Valid, bus.Peak_Value, bus.Trough_Value, bus.Beat_Interval, bus.No_Signal);
    end
  endtask

  task automatic test_reset();
    int c0;
    apply_reset();
    check_outputs_zero("reset_powerup");
    for (int k = 0; k < 170; k++) cycle(1'b1, tri_val(k, 1000, 5000, 100));
    // Asynchronous assertion between clock edges.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs_zero("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_beats();
    c0 = cyc;
    for (int k = 0; k < 200; k++) cycle(1'b1, tri_val(k, 1000, 5000, 100));
    checks++;
    if (bq_idx.size() != 1 || bq_idx[0] - c0 != 154) begin
      failures++;
      $display("FAIL reset_two_peaks got beats=%0d first_at=%0d exp beats=1 first_at=154",
               bq_idx.size(), (bq_idx.size() > 0) ? bq_idx[0] - c0 : -1);
    end
  endtask

  task automatic run_triangle(input int valid_every, input string name);
    int bad;
    apply_reset();
    clear_beats();
    for (int k = 0; k < 1000; k++) begin
      for (int g = 1; g < valid_every; g++) cycle(1'b0, int'($urandom_range(0, XMAX)));
      cycle(1'b1, tri_val(k, 1000, 5000, 100));
    end
    checks++;
    if (bq_idx.size() != 9) begin
      failures++;
      $display("FAIL %s_count got %0d beats exp 9", name, bq_idx.size());
    end
    bad = 0;
    for (int i = 0; i < bq_idx.size(); i++) begin
      if (bq_peak[i] != 5000 || bq_trough[i] != 1000 || bq_int[i] != 100) bad++;
      if (i > 0 && bq_idx[i] - bq_idx[i-1] != 100 * valid_every) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_values got %0d bad beat fields exp 0 (peak 5000 trough 1000 int 100 spacing %0d)",
               name, bad, 100 * valid_every);
    end
  endtask

  task automatic test_triangle();
    run_triangle(1, "triangle");
  endtask

  task automatic test_sparse_valid();
    run_triangle(4, "sparse");
  endtask

  task automatic test_ripple_timeout();
    apply_reset();
    clear_beats();
    for (int k = 0; k < 3000; k++) cycle(1'b1, 2900 + int'($urandom_range(0, 200)));
    checks++;
    if (bus.No_Signal !== 1'b0) begin
      failures++;
      $display("FAIL ripple_before_timeout got ns=%b exp 0", bus.No_Signal);
    end
    cycle(1'b1, 2900 + int'($urandom_range(0, 200)));
    checks++;
    if (bus.No_Signal !== 1'b1 || bq_idx.size() != 0) begin
      failures++;
      $display("FAIL ripple_timeout got ns=%b beats=%0d exp ns=1 beats=0", bus.No_Signal, bq_idx.size());
    end
    for (int k = 0; k < 154; k++) cycle(1'b1, tri_val(k, 1000, 5000, 100));
    checks++;
    if (bus.No_Signal !== 1'b1) begin
      failures++;
      $display("FAIL ripple_hold got ns=%b exp 1 before second peak", bus.No_Signal);
    end
    cycle(1'b1, tri_val(154, 1000, 5000, 100));
    checks++;
    if (bus.No_Signal !== 1'b0 || bus.Beat_Valid !== 1'b1 || bus.Peak_Value !== DATA_W'(5000)) begin
      failures++;
      $display("FAIL ripple_recover got ns=%b bv=%b pk=%0d exp ns=0 bv=1 pk=5000",
               bus.No_Signal, bus.Beat_Valid, bus.Peak_Value);
    end
  endtask

  task automatic test_refractory();
    int q[$];
    apply_reset();
    clear_beats();
    for (int k = 0; k <= 50; k++) q.push_back(1000 + 80 * k);
    for (int k = 1; k <= 10; k++) q.push_back(5000 - 400 * k);
    for (int k = 1; k <= 10; k++) q.push_back(1000 + 400 * k);
    q.push_back(4700);
    for (int k = 1; k <= 5; k++) q.push_back(4700 + 100 * k);
    for (int k = 0; k < 20; k++) q.push_back(5200);
    for (int k = 1; k <= 11; k++) q.push_back(5200 - 400 * k);
    foreach (q[i]) cycle(1'b1, q[i]);
    checks++;
    if (bq_idx.size() != 1 || bq_peak[0] != 5200 || bq_trough[0] != 1000 || bq_int[0] != 46) begin
      failures++;
      $display("FAIL refractory got beats=%0d pk=%0d tr=%0d int=%0d exp beats=1 pk=5200 tr=1000 int=46",
               bq_idx.size(), (bq_idx.size() > 0) ? bq_peak[0] : -1,
               (bq_idx.size() > 0) ? bq_trough[0] : -1, (bq_idx.size() > 0) ? bq_int[0] : -1);
    end
  endtask

  task automatic test_hysteresis_edge();
    apply_reset();
    clear_beats();
    for (int k = 0; k <= 100; k++) cycle(1'b1, tri_val(k, 1000, 5000, 100));
    // Trough side: 256 above the minimum must not confirm, 257 must.
    cycle(1'b1, 1256);
    cycle(1'b1, 900);
    cycle(1'b1, 1156);
    cycle(1'b1, 1157);
    for (int k = 0; k < 5; k++) cycle(1'b1, 5000);
    for (int k = 0; k < 3; k++) cycle(1'b1, 4744);
    checks++;
    if (bq_idx.size() != 0) begin
      failures++;
      $display("FAIL hyst_equal got %0d beats exp 0", bq_idx.size());
    end
    cycle(1'b1, 4743);
    checks++;
    if (bus.Beat_Valid !== 1'b1 || bus.Peak_Value !== DATA_W'(5000) || bus.Trough_Value !== DATA_W'(900)) begin
      failures++;
      $display("FAIL hyst_over got bv=%b pk=%0d tr=%0d exp bv=1 pk=5000 tr=900",
               bus.Beat_Valid, bus.Peak_Value, bus.Trough_Value);
    end
    cycle(1'b0, 0);
    checks++;
    if (bus.Beat_Valid !== 1'b0 || bus.Peak_Value !== DATA_W'(5000)) begin
      failures++;
      $display("FAIL strobe_one_cycle got bv=%b pk=%0d exp bv=0 pk=5000", bus.Beat_Valid, bus.Peak_Value);
    end
  endtask

  task automatic random_segments(input int nseg);
    int lo, hi, half, x;
    for (int seg = 0; seg < nseg; seg++) begin
      if (seg == 3) begin
        lo = 0; hi = XMAX;
      end else begin
        lo = int'($urandom_range(0, 400000));
        hi = lo + int'($urandom_range(100, 300000));
      end
      half = int'($urandom_range(4, 60));
      for (int k = 0; k < 2 * half; k++) begin
        x = (k < half) ? lo + (hi - lo) / half * k : hi - (hi - lo) / half * (k - half);
        x = x + int'($urandom_range(0, 150));
        if (x > XMAX) x = XMAX;
        if ($urandom_range(0, 3) == 0) cycle(1'b0, int'($urandom_range(0, XMAX)));
        cycle(1'b1, x);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    random_segments(40);
    for (int k = 0; k < 3100; k++) begin
      if ($urandom_range(0, 7) == 0) cycle(1'b0, 0);
      cycle(1'b1, 70000 + int'($urandom_range(0, 250)));
    end
    random_segments(15);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.In_Valid = 1'b0;
    bus.In_IR_Filtered = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_triangle();
    test_sparse_valid();
    test_ripple_timeout();
    test_refractory();
    test_hysteresis_edge();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ir_beat_detector.md
# ir_beat_detector

Downstream consumer of the IR FIR output: takes the 20-bit filtered IR stream and detects pulse peaks with a hysteresis-based rise/fall state machine. Reports each beat's peak amplitude, preceding trough amplitude and peak-to-peak interval in samples. Flags loss of signal when no peak arrives within a programmable window. Sits between the IR filter and the heart-rate/SpO2 computation logic, on the filter clock domain.

## Interface
- DATA_W, 20, sample width; matches the filter output width.
- CNT_W, 12, interval counter width.
- HYST, 256, hysteresis in LSBs required to confirm a peak or trough.
- MIN_INTERVAL, 40, refractory samples after a peak during which no new peak is confirmed.
- MAX_INTERVAL, 3000, samples without a peak before loss of signal is declared (must be < 2^CNT_W).

Ports:
- CLK_Filter  in  1  filter clock; all state is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- In_Valid  in  1  qualifies In_IR_Filtered; the state machine advances only on valid samples.
- In_IR_Filtered  in  DATA_W  filtered IR sample, unsigned.
- Beat_Valid  out  1  one-cycle strobe; the three result outputs below are updated together with it.
- Peak_Value  out  DATA_W  confirmed peak amplitude.
- Trough_Value  out  DATA_W  last confirmed trough before that peak.
- Beat_Interval  out  CNT_W  valid samples between this peak confirmation and the previous one.
- No_Signal  out  1  level; set on timeout, cleared on the next Beat_Valid.

## Operation
- States: IDLE, RISE, FALL. Registers: run_max, run_min, trough_reg, cnt, have_prev.
- IDLE, first valid sample x: run_max = run_min = x, cnt = 0, have_prev = 0, go to RISE.
- RISE, valid x:
  - if x > run_max, then run_max = x.
  - Peak confirmed when run_max − x > HYST and cnt ≥ MIN_INTERVAL. On confirmation, go to FALL and set run_min = x.
  - If have_prev: Beat_Valid = 1, Peak_Value = run_max, Trough_Value = trough_reg, Beat_Interval = cnt + 1.
  - Then have_prev = 1 and cnt = 0.
- FALL, valid x:
  - if x < run_min, then run_min = x.
  - Trough confirmed when x − run_min > HYST. On confirmation, trough_reg = run_min, run_max = x, go to RISE.
- cnt increments on every valid sample that does not confirm a peak. This applies in both RISE and FALL, and trough confirmation does not reset it.
- Timeout: a valid sample that would bring cnt to MAX_INTERVAL sets No_Signal = 1 and moves to IDLE. That sample is discarded, and the next valid sample re-initialises the tracking registers. After a timeout, two peaks are needed before the next Beat_Valid.
- Arithmetic:
  - Differences are computed in DATA_W+1 bits, unsigned, so no wrap occurs.
  - Strict comparisons: a difference exactly equal to HYST does not confirm.
- Simultaneous conditions on one sample: peak confirmation takes priority over timeout. A peak confirmed at cnt = MAX_INTERVAL−1 gives a beat, not a timeout.
- In_Valid low: all state holds, and Beat_Valid stays 0.

## Timing
- Reset values: Beat_Valid 0, Peak_Value 0, Trough_Value 0, Beat_Interval 0, No_Signal 0; state IDLE; all internal registers 0.
- Latency: outputs are registered. Beat_Valid is high for exactly one cycle, the clock after the confirming valid sample is sampled.
- Result outputs hold their values until the next Beat_Valid.
- No_Signal rises one clock after the timeout sample.
- Reset mid-operation: asynchronous clear of everything, with no partial beat reported. After release, behaviour is identical to power-up.
- Throughput: one valid sample per clock sustained, with no back-pressure.

## Structure
- Shared package: state encoding (IDLE = 0, RISE = 1, FALL = 2, 2-bit) and the DATA_W default constant used by the filter and this block.
- One sub-module: beat_interval_counter. It contains the CNT_W counter with enable, synchronous clear and a terminal-count flag at MAX_INTERVAL−1.
- The state machine, trackers and output registers live in the top level.

## Test plan
- Reset: assert rst_n low mid-stream → all outputs 0 asynchronously. No Beat_Valid until two peaks follow release.
- Triangle wave 1000↔5000, period 100 samples, In_Valid every cycle → first Beat_Valid after the second peak with Peak_Value 5000, Trough_Value 1000, Beat_Interval 100, repeating every 100 valid samples.
- Same wave with In_Valid high on every 4th cycle → identical values, strobes every 400 clocks.
- Ripple of amplitude 200 (below HYST) around 3000 → no Beat_Valid. No_Signal rises after 3000 valid samples; a following 1000↔5000 triangle clears it at its second peak.
- Refractory: a peak at 5000, a dip of 300 at sample 20, a rise to 5200, then a real fall → the dip is ignored and the next reported Peak_Value is 5200.
- Hysteresis edge: a drop of exactly 256 → no confirmation; a drop of 257 → confirmation.
